// File: rtl/freq_pkg.sv
// -----------------------------------------------------------------------------
// freq_pkg
// Shared types and helpers for the pulse period meter.
//   meter_state_e : measurement FSM states
//   CNT_W_DEF     : default counter / period width
//   in_window()   : inclusive unsigned window test used for period classification
// -----------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } meter_state_e;

    localparam int CNT_W_DEF = 33;

    // True when centre-tol <= val <= centre+tol. The lower bound clamps at
    // zero so that a tolerance larger than the centre cannot underflow.
    function automatic logic in_window(input logic [63:0] val,
                                       input logic [63:0] centre,
                                       input logic [63:0] tol);
        logic [63:0] lo_s;
        logic [63:0] hi_s;
        if (centre >= tol) begin
            lo_s = centre - tol;
        end else begin
            lo_s = 64'd0;
        end
        hi_s = centre + tol;
        return (val >= lo_s) && (val <= hi_s);
    endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_edge_detect
// Registered rising-edge detector. A level held high for several cycles
// produces a single one-cycle pulse on rise, one cycle after the edge.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   din  : level input, synchronous to clk
//   rise : one-cycle strobe, registered, for each 0->1 transition of din
// -----------------------------------------------------------------------------
module pulse_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_d_r;
    logic rise_r;

    // Delay the input by one cycle and register the edge strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_d_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            din_d_r <= din;
            rise_r  <= din & ~din_d_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/pulse_period_meter.sv
// -----------------------------------------------------------------------------
// pulse_period_meter
// Measures the number of clock cycles between consecutive ticks of a
// single-cycle time-base pulse, classifies the period as ~1 s / ~2 s, and
// raises a one-cycle timeout strobe when ticks stop arriving.
//
// Optional build macro: PULSE_EDGE_DET_EN
//   defined   : pulse_in passes through pulse_edge_detect, only rising edges
//               count as ticks (fixed +1 cycle latency, periods unaffected)
//   undefined : every cycle with pulse_in high is a tick
//
// Ports:
//   clk             : system clock
//   rst             : synchronous, active-high reset
//   enable          : measurement enable; low forces IDLE
//   pulse_in        : tick input, synchronous to clk
//   period_out      : last measured period in cycles
//   period_valid    : one-cycle strobe, period_out/is_1s/is_2s just updated
//   is_1s           : last period within CLK_FREQ +/- TOL
//   is_2s           : last period within 2*CLK_FREQ +/- TOL
//   timeout         : one-cycle strobe, no tick for TIMEOUT cycles
//   state_measuring : high while in MEASURE
// -----------------------------------------------------------------------------
module pulse_period_meter
    import freq_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int TOL      = 2,
    parameter int TIMEOUT  = 3 * CLK_FREQ,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             is_1s,
    output logic             is_2s,
    output logic             timeout,
    output logic             state_measuring
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [63:0]      CENTRE_1S  = 64'(CLK_FREQ);
    localparam logic [63:0]      CENTRE_2S  = 64'(CLK_FREQ) * 64'd2;
    localparam logic [63:0]      TOL_C      = 64'(TOL);

    logic             tick_s;

    meter_state_e     state_r,  state_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;
    logic [CNT_W-1:0] period_r, period_s;
    logic             valid_r,  valid_s;
    logic             is_1s_r,  is_1s_s;
    logic             is_2s_r,  is_2s_s;
    logic             tmo_r,    tmo_s;

`ifdef PULSE_EDGE_DET_EN
    pulse_edge_detect u_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .din  (pulse_in),
        .rise (tick_s)
    );
`else
    assign tick_s = pulse_in;
`endif

    // Next-state, counter and output-register logic of the measurement FSM.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        period_s = period_r;
        is_1s_s  = is_1s_r;
        is_2s_s  = is_2s_r;
        valid_s  = 1'b0;
        tmo_s    = 1'b0;

        if (!enable) begin
            // Disabling abandons any measurement; results keep their values.
            state_s = IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (tick_s) begin
                        cnt_s   = CNT_W'(1);
                        state_s = MEASURE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                MEASURE: begin
                    // A tick on the timeout cycle is still a valid measurement.
                    if (tick_s) begin
                        period_s = cnt_r;
                        is_1s_s  = in_window(64'(cnt_r), CENTRE_1S, TOL_C);
                        is_2s_s  = in_window(64'(cnt_r), CENTRE_2S, TOL_C);
                        valid_s  = 1'b1;
                        cnt_s    = CNT_W'(1);
                    end else if (cnt_r == TIMEOUT_C) begin
                        tmo_s   = 1'b1;
                        cnt_s   = '0;
                        state_s = WAIT_FIRST;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            period_r <= '0;
            valid_r  <= 1'b0;
            is_1s_r  <= 1'b0;
            is_2s_r  <= 1'b0;
            tmo_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            period_r <= period_s;
            valid_r  <= valid_s;
            is_1s_r  <= is_1s_s;
            is_2s_r  <= is_2s_s;
            tmo_r    <= tmo_s;
        end
    end

    assign period_out      = period_r;
    assign period_valid    = valid_r;
    assign is_1s           = is_1s_r;
    assign is_2s           = is_2s_r;
    assign timeout         = tmo_r;
    assign state_measuring = (state_r == MEASURE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_meter
// Self-checking bench for pulse_period_meter (default build, no edge detect).
// A timestamp-based reference model predicts every output one cycle ahead:
// it remembers the cycle of the last accepted tick and the earliest cycle at
// which ticks are accepted again after reset / disable.
// -----------------------------------------------------------------------------
module tb_pulse_period_meter;

    localparam int CLK_FREQ = 10;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 30;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             pulse_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             is_1s;
    logic             is_2s;
    logic             timeout;
    logic             state_measuring;

    pulse_period_meter #(
        .CLK_FREQ (CLK_FREQ),
        .TOL      (TOL),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .pulse_in        (pulse_in),
        .period_out      (period_out),
        .period_valid    (period_valid),
        .is_1s           (is_1s),
        .is_2s           (is_2s),
        .timeout         (timeout),
        .state_measuring (state_measuring)
    );

    // Free-running clock, period 10 time units.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state.
    bit ref_ok   = 1'b0;
    int ref_t    = 0;
    int armed_at = 0;
    bit chk_on   = 1'b0;

    // Expected outputs after the upcoming clock edge.
    bit e_valid  = 1'b0;
    bit e_tmo    = 1'b0;
    int e_period = 0;
    bit e_1s     = 1'b0;
    bit e_2s     = 1'b0;
    bit e_meas   = 1'b0;

    int gaps[13] = '{1, 5, 9, 10, 11, 15, 19, 20, 21, 29, 30, 31, 40};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit near(input int v, input int c);
        return (v >= c - TOL) && (v <= c + TOL);
    endfunction

    // One clock cycle: check outputs of the previous edge, apply new inputs,
    // and advance the reference model to predict the next edge.
    task automatic step(input bit r, input bit en, input bit p);
        int d;
        @(negedge clk);
        if (chk_on) begin
            check_eq("period_valid", 32'(period_valid), 32'(e_valid));
            check_eq("timeout", 32'(timeout), 32'(e_tmo));
            check_eq("period_out", 32'(period_out), 32'(e_period));
            check_eq("is_1s", 32'(is_1s), 32'(e_1s));
            check_eq("is_2s", 32'(is_2s), 32'(e_2s));
            check_eq("state_measuring", 32'(state_measuring), 32'(e_meas));
        end
        rst      = r;
        enable   = en;
        pulse_in = p;

        e_valid = 1'b0;
        e_tmo   = 1'b0;
        if (r) begin
            ref_ok   = 1'b0;
            armed_at = cyc + 2;
            e_period = 0;
            e_1s     = 1'b0;
            e_2s     = 1'b0;
        end else if (!en) begin
            ref_ok   = 1'b0;
            armed_at = cyc + 2;
        end else if (cyc >= armed_at) begin
            if (ref_ok) begin
                d = cyc - ref_t;
                if (p) begin
                    e_valid  = 1'b1;
                    e_period = d;
                    e_1s     = near(d, CLK_FREQ);
                    e_2s     = near(d, 2 * CLK_FREQ);
                    ref_t    = cyc;
                end else if (d == TIMEOUT) begin
                    e_tmo  = 1'b1;
                    ref_ok = 1'b0;
                end
            end else if (p) begin
                ref_ok = 1'b1;
                ref_t  = cyc;
            end
        end
        e_meas = ref_ok;
        chk_on = 1'b1;
        cyc++;
    endtask

    // Idle for gap-1 cycles, then tick on the gap-th cycle.
    task automatic tick_after(input int gap);
        for (int i = 1; i < gap; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int r;
        int gap;
        int width;
        rst      = 1'b1;
        enable   = 1'b0;
        pulse_in = 1'b0;

        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Nominal 1 s ticks, then 2 s ticks, then unclassified / edge values.
        tick_after(3);
        repeat (3) tick_after(10);
        tick_after(20);
        tick_after(19);
        tick_after(21);
        tick_after(15);
        tick_after(9);
        tick_after(8);
        tick_after(12);
        // Silence long enough for a timeout, then re-arm.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
        tick_after(1);
        tick_after(10);
        tick_after(30);
        tick_after(31);
        tick_after(10);
        // Reset during a measurement.
        tick_after(10);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        tick_after(5);
        tick_after(10);
        // Enable dropped for 5 cycles with ticks present.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        tick_after(4);
        tick_after(10);
        // Multi-cycle high level: every high cycle is a tick.
        for (int i = 0; i < 3; i++) begin
            tick_after(8);
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b1);
        end

        // Randomized traffic.
        repeat (150) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                step(1'b1, 1'(r[0]), 1'(r[1]));
            end else if (r < 12) begin
                repeat ($urandom_range(1, 5)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                gap   = gaps[$urandom_range(0, 12)];
                width = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
                tick_after(gap);
                for (int i = 1; i < width; i++) step(1'b0, 1'b1, 1'b1);
            end
        end

        step(1'b0, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
